item_list_reader: RTL and testbench

Read-side companion to the item map writer. On a `start` pulse it snapshots the packed item list and walks slots `0..quantity-1`. For each visible item it emits one decoded record (index, type, left, top, flags) over a valid/ready handshake to the drawing and collision logic. One scan is one pass, closed by a `done` pulse carrying the emitted count.

---
 rtl/item_pkg.sv | 37 +++
 rtl/item_list_reader_if.sv | 23 ++
 rtl/item_field_decode.sv | 39 +++
 rtl/item_list_reader.sv | 178 +++++++++++++++++
 tb/tb_item_list_reader.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/item_pkg.sv
// Shared constants for the packed item list: slot field positions, type codes and reader states.
// The writer block uses the same field positions.
package item_pkg;

  localparam int ITEM_W     = 32;
  localparam int MAX_ITEMS  = 32;
  localparam int IDX_W      = 6;

  localparam int X_HI       = 31;
  localparam int X_LO       = 19;
  localparam int Y_HI       = 18;
  localparam int Y_LO       = 7;
  localparam int VIS        = 1;
  localparam int MOVED      = 0;
  localparam int FRAC_SHIFT = 4;

  localparam logic [1:0] TYPE_GOLD    = 2'd0;
  localparam logic [1:0] TYPE_STONE   = 2'd1;
  localparam logic [1:0] TYPE_DIAMOND = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [IDX_W-1:0] clamp_limit(input logic [IDX_W-1:0] quantity,
                                                   input logic [IDX_W-1:0] max_items);
    if (quantity > max_items) begin
      clamp_limit = max_items;
    end else begin
      clamp_limit = quantity;
    end
  endfunction

endpackage

// File: rtl/item_list_reader_if.sv
// Decoded item record stream from the list reader to the drawing/collision consumers.
interface item_list_reader_if;

  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_index;
  logic [1:0] out_type;
  logic [8:0] out_x;
  logic [7:0] out_y;
  logic       out_moved;
  logic       out_visible;

  modport master (
    output out_valid, out_index, out_type, out_x, out_y, out_moved, out_visible,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_index, out_type, out_x, out_y, out_moved, out_visible,
    output out_ready
  );

endinterface

// File: rtl/item_field_decode.sv
// Combinational decode of one packed slot word into type, screen position and flag bits.
module item_field_decode
  import item_pkg::*;
#(
  parameter int GOLD_END  = 8,
  parameter int STONE_END = 16
) (
  input  logic [ITEM_W-1:0] slot,
  input  logic [IDX_W-1:0]  index,
  output logic [1:0]        item_type,
  output logic [8:0]        x,
  output logic [7:0]        y,
  output logic              moved,
  output logic              visible
);

  localparam logic [IDX_W-1:0] GOLD_LIM  = IDX_W'(GOLD_END);
  localparam logic [IDX_W-1:0] STONE_LIM = IDX_W'(STONE_END);

  // Positions are stored with 4 fractional bits; dropping them truncates toward zero.
  assign x       = slot[X_HI:X_LO+FRAC_SHIFT];
  assign y       = slot[Y_HI:Y_LO+FRAC_SHIFT];
  assign moved   = slot[MOVED];
  assign visible = slot[VIS];

  logic unused_bits_s;
  assign unused_bits_s = ^{slot[X_LO+FRAC_SHIFT-1:X_LO], slot[Y_LO+FRAC_SHIFT-1:VIS+1]};

  always_comb begin
    if (index < GOLD_LIM) begin
      item_type = TYPE_GOLD;
    end else if (index < STONE_LIM) begin
      item_type = TYPE_STONE;
    end else begin
      item_type = TYPE_DIAMOND;
    end
  end

endmodule

// File: rtl/item_list_reader.sv
// Scans a snapshot of the packed item list and streams one decoded record per visible slot,
// closing each scan with a done pulse carrying the number of accepted records.
module item_list_reader #(
  parameter int MAX_ITEMS   = item_pkg::MAX_ITEMS,
  parameter int ITEM_W      = item_pkg::ITEM_W,
  parameter int GOLD_END    = 8,
  parameter int STONE_END   = 16,
  parameter int SKIP_HIDDEN = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [MAX_ITEMS*ITEM_W-1:0] data,
  input  logic [5:0]                  quantity,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [5:0]                  emitted,
  item_list_reader_if.master          rec
);

  import item_pkg::*;

  localparam int               SEL_W     = $clog2(MAX_ITEMS);
  localparam logic [IDX_W-1:0] LIMIT_MAX = IDX_W'(MAX_ITEMS);
  localparam logic [IDX_W-1:0] ONE       = IDX_W'(1);
  localparam bit               SHOW_ALL  = (SKIP_HIDDEN == 0);

  state_t            state_r;
  state_t            state_n;
  logic [ITEM_W-1:0] snap_r [MAX_ITEMS];
  logic [IDX_W-1:0]  idx_r;
  logic [IDX_W-1:0]  limit_r;
  logic [IDX_W-1:0]  emitted_r;
  logic              busy_r;
  logic              done_r;
  logic              valid_r;
  logic [IDX_W-1:0]  index_r;
  logic [1:0]        type_r;
  logic [8:0]        x_r;
  logic [7:0]        y_r;
  logic              moved_r;
  logic              visible_r;

  logic              load_s;
  logic              emit_s;
  logic              advance_s;
  logic              accept_s;
  logic [ITEM_W-1:0] slot_s;
  logic [1:0]        type_s;
  logic [8:0]        x_s;
  logic [7:0]        y_s;
  logic              moved_s;
  logic              visible_s;

  // When idx equals a limit of MAX_ITEMS the low bits alias slot 0, but SCAN never uses it then.
  assign slot_s = snap_r[idx_r[SEL_W-1:0]];

  item_field_decode #(
    .GOLD_END  (GOLD_END),
    .STONE_END (STONE_END)
  ) u_decode (
    .slot      (slot_s),
    .index     (idx_r),
    .item_type (type_s),
    .x         (x_s),
    .y         (y_s),
    .moved     (moved_s),
    .visible   (visible_s)
  );

  always_comb begin
    state_n   = state_r;
    load_s    = 1'b0;
    emit_s    = 1'b0;
    advance_s = 1'b0;
    accept_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_SCAN;
          load_s  = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (idx_r == limit_r) begin
          state_n = ST_DONE;
        end else if (visible_s || SHOW_ALL) begin
          state_n = ST_EMIT;
          emit_s  = 1'b1;
        end else begin
          state_n   = ST_SCAN;
          advance_s = 1'b1;
        end
      end
      ST_EMIT: begin
        if (rec.out_ready) begin
          state_n  = ST_SCAN;
          accept_s = 1'b1;
        end else begin
          state_n = ST_EMIT;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_n;
      busy_r  <= (state_n != ST_IDLE);
      done_r  <= (state_n == ST_DONE);
      valid_r <= (state_n == ST_EMIT);
    end
  end

  // Record fields only load on entry to EMIT, so they stay frozen across a stalled handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MAX_ITEMS; i++) begin
        snap_r[i] <= '0;
      end
      idx_r     <= '0;
      limit_r   <= '0;
      emitted_r <= '0;
      index_r   <= '0;
      type_r    <= TYPE_GOLD;
      x_r       <= 9'd0;
      y_r       <= 8'd0;
      moved_r   <= 1'b0;
      visible_r <= 1'b0;
    end else if (load_s) begin
      for (int i = 0; i < MAX_ITEMS; i++) begin
        snap_r[i] <= data[i*ITEM_W +: ITEM_W];
      end
      limit_r   <= clamp_limit(quantity, LIMIT_MAX);
      idx_r     <= '0;
      emitted_r <= '0;
    end else if (emit_s) begin
      index_r   <= idx_r;
      type_r    <= type_s;
      x_r       <= x_s;
      y_r       <= y_s;
      moved_r   <= moved_s;
      visible_r <= visible_s;
    end else if (accept_s) begin
      idx_r     <= idx_r + ONE;
      emitted_r <= emitted_r + ONE;
    end else if (advance_s) begin
      idx_r <= idx_r + ONE;
    end else begin
      idx_r <= idx_r;
    end
  end

  assign busy            = busy_r;
  assign done            = done_r;
  assign emitted         = emitted_r;
  assign rec.out_valid   = valid_r;
  assign rec.out_index   = index_r;
  assign rec.out_type    = type_r;
  assign rec.out_x       = x_r;
  assign rec.out_y       = y_r;
  assign rec.out_moved   = moved_r;
  assign rec.out_visible = visible_r;

endmodule

// File: tb/tb_item_list_reader.sv
// Directed bench for item_list_reader: record decode, skipping, clamping, stalls, reset and timing.
module tb_item_list_reader;

  logic          clock = 1'b0;
  logic          reset;
  logic [1023:0] data;
  logic [5:0]    quantity;
  logic          start;
  logic          busy;
  logic          done;
  logic [5:0]    emitted;

  item_list_reader_if rec_bus();

  item_list_reader dut (
    .clock    (clock),
    .reset    (reset),
    .data     (data),
    .quantity (quantity),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .emitted  (emitted),
    .rec      (rec_bus)
  );

  always #5 clock = ~clock;

  int         errors = 0;
  int         checks = 0;
  int         n_done;
  int         valid_seen;
  logic [5:0] emitted_at_done;
  int         r_idx[$];
  int         r_type[$];
  int         r_x[$];
  int         r_y[$];
  int         r_moved[$];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_slot(input logic [12:0] xr, input logic [11:0] yr,
                                          input logic vis, input logic mv);
    return {xr, yr, 5'd0, vis, mv};
  endfunction

  task automatic set_slot(input int i, input logic [31:0] w);
    data[i*32 +: 32] = w;
  endtask

  // Pulses start, collects accepted records until done or the budget runs out.
  task automatic run_scan(input int budget, input int restart_at);
    int n;
    r_idx.delete(); r_type.delete(); r_x.delete(); r_y.delete(); r_moved.delete();
    n_done = -1;
    valid_seen = 0;
    emitted_at_done = 6'd0;
    start = 1'b1;
    n = 0;
    while (n < budget && n_done < 0) begin
      tick();
      n++;
      if (n == 1 || n == restart_at + 1) start = 1'b0;
      if (n == restart_at) start = 1'b1;
      if (rec_bus.out_valid) begin
        valid_seen++;
        if (rec_bus.out_ready) begin
          r_idx.push_back(int'(rec_bus.out_index));
          r_type.push_back(int'(rec_bus.out_type));
          r_x.push_back(int'(rec_bus.out_x));
          r_y.push_back(int'(rec_bus.out_y));
          r_moved.push_back(int'(rec_bus.out_moved));
        end
      end
      if (done) begin
        n_done = n;
        emitted_at_done = emitted;
      end
    end
    start = 1'b0;
    check("done_reached", done, 1);
  endtask

  task automatic finish_scan(input string tag, input int exp_emitted);
    tick();
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_done_low"}, done, 0);
    check({tag, "_emitted_held"}, emitted, exp_emitted);
  endtask

  initial begin
    int k;
    int seq_bad;
    reset = 1'b1;
    start = 1'b0;
    quantity = 6'd0;
    data = '0;
    rec_bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_valid", rec_bus.out_valid, 0);
    check("rst_done", done, 0);
    check("rst_emitted", emitted, 0);
    check("rst_index", rec_bus.out_index, 0);
    check("rst_type", rec_bus.out_type, 0);
    check("rst_x", rec_bus.out_x, 0);
    check("rst_y", rec_bus.out_y, 0);
    check("rst_flags", {rec_bus.out_moved, rec_bus.out_visible}, 0);
    reset = 1'b0;
    rec_bus.out_ready = 1'b1;
    tick();

    // Three visible slots; slot 3 is visible but beyond quantity.
    set_slot(0, mk_slot(13'h00A0, 12'h0F0, 1'b1, 1'b0));
    set_slot(1, mk_slot(13'h0140, 12'h050, 1'b1, 1'b1));
    set_slot(2, mk_slot(13'h1FFF, 12'hFFF, 1'b1, 1'b0));
    set_slot(3, mk_slot(13'h0100, 12'h100, 1'b1, 1'b0));
    quantity = 6'd3;
    run_scan(100, -1);
    check("a_count", r_idx.size(), 3);
    if (r_idx.size() == 3) begin
      check("a_r0_index", r_idx[0], 0);
      check("a_r0_x", r_x[0], 10);
      check("a_r0_y", r_y[0], 15);
      check("a_r0_moved", r_moved[0], 0);
      check("a_r1_index", r_idx[1], 1);
      check("a_r1_x", r_x[1], 20);
      check("a_r1_y", r_y[1], 5);
      check("a_r1_moved", r_moved[1], 1);
      check("a_r1_type", r_type[1], 0);
      check("a_r2_x", r_x[2], 511);
      check("a_r2_y", r_y[2], 255);
    end
    check("a_emitted", emitted_at_done, 3);
    check("a_done_cycle", n_done, 8);
    finish_scan("a", 3);

    // Only slots 9 and 17 visible; start lands in the cycle busy falls.
    data = '0;
    set_slot(5, mk_slot(13'h0300, 12'h300, 1'b0, 1'b1));
    set_slot(9, mk_slot(13'h0320, 12'h640, 1'b1, 1'b0));
    set_slot(17, mk_slot(13'h1000, 12'h800, 1'b1, 1'b1));
    set_slot(25, mk_slot(13'h0010, 12'h010, 1'b1, 1'b0));
    quantity = 6'd20;
    run_scan(100, -1);
    check("b_count", r_idx.size(), 2);
    if (r_idx.size() == 2) begin
      check("b_r0_index", r_idx[0], 9);
      check("b_r0_type", r_type[0], 1);
      check("b_r0_x", r_x[0], 50);
      check("b_r0_y", r_y[0], 100);
      check("b_r1_index", r_idx[1], 17);
      check("b_r1_type", r_type[1], 2);
      check("b_r1_x", r_x[1], 256);
      check("b_r1_y", r_y[1], 128);
      check("b_r1_moved", r_moved[1], 1);
    end
    check("b_emitted", emitted_at_done, 2);
    check("b_done_cycle", n_done, 24);
    finish_scan("b", 2);

    // Empty list.
    quantity = 6'd0;
    run_scan(20, -1);
    check("c_done_cycle", n_done, 2);
    check("c_emitted", emitted_at_done, 0);
    check("c_no_valid", valid_seen, 0);
    finish_scan("c", 0);

    // Stall in EMIT while the inputs churn.
    data = '0;
    set_slot(0, mk_slot(13'h0AB0, 12'hCD0, 1'b1, 1'b1));
    quantity = 6'd1;
    rec_bus.out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (k < 10 && !rec_bus.out_valid) begin
      tick();
      k++;
    end
    check("d_valid_up", rec_bus.out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      data = {32{$urandom()}};
      quantity = 6'($urandom_range(0, 63));
      tick();
      check("d_stall_valid", rec_bus.out_valid, 1);
      check("d_stall_x", rec_bus.out_x, 171);
      check("d_stall_y", rec_bus.out_y, 205);
    end
    check("d_stall_index", rec_bus.out_index, 0);
    check("d_stall_emitted", emitted, 0);
    rec_bus.out_ready = 1'b1;
    tick();
    check("d_valid_drop", rec_bus.out_valid, 0);
    check("d_one_accept", emitted, 1);
    tick();
    check("d_done", done, 1);
    check("d_done_emitted", emitted, 1);
    finish_scan("d", 1);

    // Quantity above the list size clamps to 32; a second start mid-scan is ignored.
    for (int i = 0; i < 32; i++) begin
      set_slot(i, mk_slot(13'(i * 16), 12'(i * 16), 1'b1, 1'(i)));
    end
    quantity = 6'd40;
    run_scan(200, 10);
    check("e_count", r_idx.size(), 32);
    if (r_idx.size() == 32) begin
      seq_bad = 0;
      for (int i = 0; i < 32; i++) begin
        if (r_idx[i] != i) seq_bad++;
      end
      check("e_sequence", seq_bad, 0);
      check("e_last_index", r_idx[31], 31);
      check("e_last_x", r_x[31], 31);
      check("e_last_moved", r_moved[31], 1);
      check("e_type7", r_type[7], 0);
      check("e_type8", r_type[8], 1);
      check("e_type15", r_type[15], 1);
      check("e_type16", r_type[16], 2);
    end
    check("e_emitted", emitted_at_done, 32);
    check("e_done_cycle", n_done, 66);
    finish_scan("e", 32);

    // Reset while a record is presented, then a clean rescan.
    quantity = 6'd3;
    rec_bus.out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (k < 10 && !rec_bus.out_valid) begin
      tick();
      k++;
    end
    check("f_valid_up", rec_bus.out_valid, 1);
    reset = 1'b1;
    tick();
    check("f_rst_valid", rec_bus.out_valid, 0);
    check("f_rst_busy", busy, 0);
    check("f_rst_emitted", emitted, 0);
    reset = 1'b0;
    rec_bus.out_ready = 1'b1;
    run_scan(50, -1);
    check("f_count", r_idx.size(), 3);
    if (r_idx.size() == 3) begin
      check("f_first_index", r_idx[0], 0);
      check("f_first_x", r_x[0], 0);
    end
    check("f_emitted", emitted_at_done, 3);
    check("f_done_cycle", n_done, 8);
    finish_scan("f", 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
